// File: rtl/muldiv_sequencer_if.sv
// EX-stage to HI/LO multiply-divide sequencer signal bundle.
interface muldiv_sequencer_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_FUNC   = 6,
  parameter int NB_ALU_OP = 3
);
  logic                 i_valid;
  logic [NB_ALU_OP-1:0] i_alu_op;
  logic [NB_FUNC-1:0]   i_func;
  logic [NB_DATA-1:0]   i_rs;
  logic [NB_DATA-1:0]   i_rt;
  logic                 i_flush;
  logic                 o_stall;
  logic                 o_busy;
  logic                 o_done;
  logic [NB_DATA-1:0]   o_result;
  logic                 o_result_valid;

  modport master (
    output i_valid, i_alu_op, i_func, i_rs, i_rt, i_flush,
    input  o_stall, o_busy, o_done, o_result, o_result_valid
  );

  modport slave (
    input  i_valid, i_alu_op, i_func, i_rs, i_rt, i_flush,
    output o_stall, o_busy, o_done, o_result, o_result_valid
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/DIV unit owning HI/LO: NB_DATA busy cycles plus one fix-up cycle, HI/LO visible two cycles later.
// Any HI/LO instruction arriving while not idle is stalled until the unit returns to IDLE.
module muldiv_sequencer #(
  parameter int NB_DATA   = 32,
  parameter int NB_FUNC   = 6,
  parameter int NB_ALU_OP = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  muldiv_sequencer_if.slave bus
);
  localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_ALU_OP-1:0] EXE_ALUOP_FUNC = NB_ALU_OP'(3'b010);
  localparam logic [NB_FUNC-1:0] FN_MULT  = NB_FUNC'(6'b011000);
  localparam logic [NB_FUNC-1:0] FN_MULTU = NB_FUNC'(6'b011001);
  localparam logic [NB_FUNC-1:0] FN_DIV   = NB_FUNC'(6'b011010);
  localparam logic [NB_FUNC-1:0] FN_DIVU  = NB_FUNC'(6'b011011);
  localparam logic [NB_FUNC-1:0] FN_MFHI  = NB_FUNC'(6'b010000);
  localparam logic [NB_FUNC-1:0] FN_MTHI  = NB_FUNC'(6'b010001);
  localparam logic [NB_FUNC-1:0] FN_MFLO  = NB_FUNC'(6'b010010);
  localparam logic [NB_FUNC-1:0] FN_MTLO  = NB_FUNC'(6'b010011);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t             state_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [NB_DATA-1:0] hi_q, lo_q, rs_q, rt_q;
  logic [NB_DATA-1:0] mag_q, acc_q, sh_q;
  logic               div_q, sgn_q, busy_q, done_q;

  logic               fn_sel, is_mul, is_div, is_mf, is_mt, is_req, op_sgn;
  logic [NB_DATA-1:0] rs_mag, rt_mag;
  logic [NB_DATA:0]   mul_sum, div_shift;
  logic               div_ge;
  logic [NB_DATA-1:0] div_diff;
  logic               rs_neg, res_neg;
  logic [2*NB_DATA-1:0] prod_mag, prod_fix;
  logic [NB_DATA-1:0] quo_fix, rem_fix, hi_d, lo_d;
  logic               res_vld;

  always_comb begin
    fn_sel = bus.i_valid && (bus.i_alu_op == EXE_ALUOP_FUNC);
    is_mul = fn_sel && (bus.i_func == FN_MULT || bus.i_func == FN_MULTU);
    is_div = fn_sel && (bus.i_func == FN_DIV  || bus.i_func == FN_DIVU);
    is_mf  = fn_sel && (bus.i_func == FN_MFHI || bus.i_func == FN_MFLO);
    is_mt  = fn_sel && (bus.i_func == FN_MTHI || bus.i_func == FN_MTLO);
    is_req = is_mul || is_div || is_mf || is_mt;
    op_sgn = (bus.i_func == FN_MULT) || (bus.i_func == FN_DIV);
    rs_mag = (op_sgn && bus.i_rs[NB_DATA-1]) ? -bus.i_rs : bus.i_rs;
    rt_mag = (op_sgn && bus.i_rt[NB_DATA-1]) ? -bus.i_rt : bus.i_rt;
  end

  // acc_q:sh_q is the {high, low} shift pair; mag_q is multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? mag_q : '0)};
    div_shift = {acc_q, sh_q[NB_DATA-1]};
    div_ge    = div_shift >= {1'b0, mag_q};
    div_diff  = div_shift[NB_DATA-1:0] - mag_q;

    rs_neg   = sgn_q && rs_q[NB_DATA-1];
    res_neg  = rs_neg ^ (sgn_q && rt_q[NB_DATA-1]);
    prod_mag = {acc_q, sh_q};
    prod_fix = res_neg ? -prod_mag : prod_mag;
    quo_fix  = res_neg ? -sh_q : sh_q;
    rem_fix  = rs_neg ? -acc_q : acc_q;

    hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
    lo_d = prod_fix[NB_DATA-1:0];
    if (div_q) begin
      if (rt_q == '0) begin
        hi_d = rs_q;
        lo_d = '1;
      end else begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (!bus.i_flush) begin
            if (is_mul || is_div) begin
              state_q <= ST_BUSY;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              rs_q    <= bus.i_rs;
              rt_q    <= bus.i_rt;
              div_q   <= is_div;
              sgn_q   <= op_sgn;
              acc_q   <= '0;
              sh_q    <= is_div ? rs_mag : rt_mag;
              mag_q   <= is_div ? rt_mag : rs_mag;
            end else if (is_mt) begin
              if (bus.i_func == FN_MTHI) hi_q <= bus.i_rs;
              else                       lo_q <= bus.i_rs;
            end
          end
        end
        ST_BUSY: begin
          if (bus.i_flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (div_q) begin
              acc_q <= div_ge ? div_diff : div_shift[NB_DATA-1:0];
              sh_q  <= {sh_q[NB_DATA-2:0], div_ge};
            end else begin
              acc_q <= mul_sum[NB_DATA:1];
              sh_q  <= {mul_sum[0], sh_q[NB_DATA-1:1]};
            end
            cnt_q <= cnt_q + NB_CNT'(1);
            if (cnt_q == NB_CNT'(NB_DATA-1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (!bus.i_flush) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates the read port so nothing looks valid while reset is held.
  assign res_vld            = !i_reset && (state_q == ST_IDLE) && is_mf;
  assign bus.o_result_valid = res_vld;
  assign bus.o_result       = !res_vld ? '0 : ((bus.i_func == FN_MFHI) ? hi_q : lo_q);
  assign bus.o_stall        = (state_q != ST_IDLE) && is_req;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of MULT/DIV results plus stall, flush and reset sequences.
module tb_muldiv_sequencer;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  typedef struct {
    string       name;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[12];

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] func, input logic [31:0] rs, input logic [31:0] rt);
    bus.i_valid  = 1'b1;
    bus.i_alu_op = ALU_FUNC;
    bus.i_func   = func;
    bus.i_rs     = rs;
    bus.i_rt     = rt;
    bus.i_flush  = 1'b0;
  endtask

  task automatic idle();
    bus.i_valid  = 1'b0;
    bus.i_alu_op = 3'b000;
    bus.i_func   = 6'b000000;
    bus.i_rs     = 32'h0;
    bus.i_rt     = 32'h0;
    bus.i_flush  = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    drive(F_MFHI, 32'h0, 32'h0);
    #1;
    chk({tag, " mfhi valid"}, {31'b0, bus.o_result_valid}, 32'd1);
    chk({tag, " hi"}, bus.o_result, hi);
    drive(F_MFLO, 32'h0, 32'h0);
    #1;
    chk({tag, " lo"}, bus.o_result, lo);
    idle();
  endtask

  task automatic run_vec(input vec_t v);
    tick();
    drive(v.func, v.rs, v.rt);
    #1;
    chk({v.name, " start stall"}, {31'b0, bus.o_stall}, 32'd0);
    tick();
    idle();
    #1;
    chk({v.name, " busy c1"}, {31'b0, bus.o_busy}, 32'd1);
    for (int c = 2; c <= 32; c++) tick();
    #1;
    chk({v.name, " done c32"}, {31'b0, bus.o_done}, 32'd0);
    tick();
    #1;
    chk({v.name, " done c33"}, {31'b0, bus.o_done}, 32'd1);
    tick();
    #1;
    chk({v.name, " busy c34"}, {31'b0, bus.o_busy}, 32'd0);
    read_hilo(v.name, v.hi, v.lo);
  endtask

  initial begin
    int stalls;
    int rvs;

    vecs[0]  = '{"mult -2*3",     F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu max*max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"mult min*min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{"multu x*16",    F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[4]  = '{"mult 7*-1",     F_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[5]  = '{"divu 100/7",    F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{"div -7/2",      F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{"div 7/-2",      F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{"div -8/-3",     F_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    vecs[9]  = '{"div 5/0",       F_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[10] = '{"divu big/0",    F_DIVU,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[11] = '{"div min/-1",    F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    rst = 1'b1;
    drive(F_MFHI, 32'h0, 32'h0);
    #12;
    chk("reset busy", {31'b0, bus.o_busy}, 32'd0);
    chk("reset done", {31'b0, bus.o_done}, 32'd0);
    chk("reset stall", {31'b0, bus.o_stall}, 32'd0);
    chk("reset result_valid", {31'b0, bus.o_result_valid}, 32'd0);
    #11;
    rst = 1'b0;
    idle();
    tick();
    read_hilo("after reset", 32'h0, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // MFLO held behind a MULT, with an unrelated ADD slipping through in cycle 5.
    tick();
    drive(F_MULT, 32'd3, 32'd5);
    stalls = 0;
    rvs    = 0;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 5) drive(F_ADD, 32'h0, 32'h0);
      else        drive(F_MFLO, 32'h0, 32'h0);
      #1;
      if (c == 5) chk("add no stall c5", {31'b0, bus.o_stall}, 32'd0);
      else if (bus.o_stall) stalls++;
      if (bus.o_result_valid) rvs++;
    end
    chk("mflo stall cycles", stalls, 32'd32);
    chk("mflo early valid", rvs, 32'd0);
    tick();
    drive(F_MFLO, 32'h0, 32'h0);
    #1;
    chk("mflo c34 stall", {31'b0, bus.o_stall}, 32'd0);
    chk("mflo c34 valid", {31'b0, bus.o_result_valid}, 32'd1);
    chk("mflo c34 lo", bus.o_result, 32'd15);
    idle();

    tick();
    drive(F_MTHI, 32'h1234, 32'h0);
    tick();
    drive(F_MFHI, 32'h0, 32'h0);
    #1;
    chk("mthi then mfhi", bus.o_result, 32'h1234);
    tick();
    drive(F_MTLO, 32'hBBBB, 32'h0);
    tick();
    idle();

    // Flush in IDLE must suppress both an MT write and an operation start.
    drive(F_MTHI, 32'h5555, 32'h0);
    bus.i_flush = 1'b1;
    tick();
    drive(F_MULT, 32'd2, 32'd2);
    bus.i_flush = 1'b1;
    tick();
    idle();
    #1;
    chk("idle flush no start", {31'b0, bus.o_busy}, 32'd0);
    read_hilo("idle flush", 32'h1234, 32'hBBBB);

    tick();
    drive(F_MULTU, 32'd2, 32'd3);
    for (int c = 1; c <= 9; c++) begin
      tick();
      idle();
    end
    #1;
    chk("multu busy c9", {31'b0, bus.o_busy}, 32'd1);
    tick();
    bus.i_flush = 1'b1;
    tick();
    idle();
    #1;
    chk("flush busy c11", {31'b0, bus.o_busy}, 32'd0);
    read_hilo("busy flush", 32'h1234, 32'hBBBB);

    tick();
    drive(F_DIV, 32'd100, 32'd7);
    for (int c = 1; c <= 19; c++) begin
      tick();
      idle();
    end
    #1;
    chk("div busy c19", {31'b0, bus.o_busy}, 32'd1);
    tick();
    drive(F_MFHI, 32'h0, 32'h0);
    #1;
    chk("div mfhi stall c20", {31'b0, bus.o_stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst busy", {31'b0, bus.o_busy}, 32'd0);
    chk("async rst done", {31'b0, bus.o_done}, 32'd0);
    chk("async rst stall", {31'b0, bus.o_stall}, 32'd0);
    chk("async rst result_valid", {31'b0, bus.o_result_valid}, 32'd0);
    chk("async rst result", bus.o_result, 32'h0);
    #2;
    rst = 1'b0;
    idle();
    tick();
    read_hilo("post async rst", 32'h0, 32'h0);
    for (int c = 0; c < 20; c++) tick();
    chk("no late busy", {31'b0, bus.o_busy}, 32'd0);
    read_hilo("no late write", 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter NB_DATA, default 32: operand, HI and LO width.
REQ-002 Parameter NB_FUNC, default 6: function-field width.
REQ-003 Parameter NB_ALU_OP, default 3: ALU-op width.
REQ-004 i_clock  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_valid  input  1  EX-stage instruction valid this cycle.
REQ-007 i_alu_op  input  NB_ALU_OP  ALU op from control; block acts only when equal to EXE_ALUOP_FUNC (3'b010).
REQ-008 i_func  input  NB_FUNC  R-type function field.
REQ-009 i_rs, i_rt  input  NB_DATA each  operands (dividend/multiplicand = rs).
REQ-010 i_flush  input  1  synchronous pipeline flush.
REQ-011 o_stall  output  1  freeze IF/ID/EX.
REQ-012 o_busy  output  1  operation in progress.
REQ-013 o_done  output  1  one-cycle pulse in DONE state.
REQ-014 o_result  output  NB_DATA  HI or LO for MFHI/MFLO.
REQ-015 o_result_valid  output  1  o_result usable this cycle.

Function
REQ-016 Decode SHALL be: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011; any other func is ignored.
REQ-017 A request SHALL be i_valid and i_alu_op == EXE_ALUOP_FUNC and a decoded func.
REQ-018 FSM states SHALL be IDLE, BUSY, DONE.
REQ-019 IDLE->BUSY SHALL occur on a MULT/MULTU/DIV/DIVU request without i_flush; operands are latched and the iteration counter is cleared on that edge.
REQ-020 BUSY SHALL last exactly NB_DATA cycles (counter 0..NB_DATA-1), one shift-add or restoring-subtract step per cycle, then go to DONE.
REQ-021 DONE SHALL last one cycle: sign fix-up applied, HI/LO written on the DONE->IDLE edge.
REQ-022 Latency: request in cycle 0 -> BUSY cycles 1..32 -> DONE cycle 33 -> new HI/LO visible cycle 34.
REQ-023 Signed ops SHALL operate on magnitudes; product/quotient negated when operand signs differ; remainder takes the sign of rs.
REQ-024 Multiply: HI = product[63:32], LO = product[31:0].
REQ-025 Divide: LO = quotient, HI = remainder.
REQ-026 Divide by zero (DIV or DIVU) SHALL give LO = all ones, HI = i_rs as latched.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-028 o_busy SHALL be 1 in BUSY and DONE, 0 in IDLE.
REQ-029 o_stall SHALL be 1 when state != IDLE and a request of any decoded func is present; non-HI/LO instructions never stall.
REQ-030 A request stalled by o_stall SHALL be held by the pipeline and accepted in the first IDLE cycle.
REQ-031 MTHI/MTLO in IDLE SHALL write HI/LO from i_rs on the next edge.
REQ-032 MFHI/MFLO in IDLE: o_result = HI/LO combinationally, o_result_valid = 1; otherwise o_result_valid = 0 and o_result = 0.
REQ-033 i_flush in BUSY or DONE SHALL return to IDLE next edge with HI/LO unchanged.
REQ-034 i_flush in IDLE SHALL suppress any start or MT write that cycle (flush wins).

Reset
REQ-035 i_reset SHALL immediately force IDLE; counter, HI and LO = 0; o_stall, o_busy, o_done, o_result_valid = 0.
REQ-036 Reset mid-operation SHALL discard the operation; no HI/LO write.

Verification
REQ-037 MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> o_done in cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 34.
REQ-038 DIVU rs=100, rt=7 -> LO=14, HI=2. DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-039 DIV rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-040 MFLO issued in cycle 1 after MULT -> o_stall=1 in cycles 1..33; in cycle 34 o_result_valid=1 with the new LO. An ADD in cycle 5 -> o_stall=0.
REQ-041 i_flush in cycle 10 of MULTU -> IDLE in cycle 11, o_busy=0, HI/LO keep prior values. MTHI 0x1234 then MFHI -> o_result=0x1234.
REQ-042 i_reset pulsed in cycle 20 of DIV, asynchronous to the clock -> all outputs 0 immediately; HI=LO=0 after release.
